// File: rtl/lock_key_tracker.sv
// rtl/lock_key_tracker.sv - per-channel lock-key tracker (toggle or momentary) with shift/capital flags.
// Toggle channels wait for release of their own key only; capital = caps lock XOR shift.
module lock_key_tracker #(
  parameter int                  N_CH           = 3,
  parameter logic [9*N_CH-1:0]   KEY_CODES      = {9'h07E, 9'h077, 9'h058},
  parameter logic [N_CH-1:0]     MOMENTARY_MASK = '0,
  parameter int                  CAPS_IDX       = 0,
  parameter logic [8:0]          LSHIFT_CODE    = 9'h012,
  parameter logic [8:0]          RSHIFT_CODE    = 9'h059
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [511:0]      key_down,
  input  logic [8:0]        last_change,
  input  logic              key_valid,
  input  logic              clear_all,
  output logic [N_CH-1:0]   lock_state,
  output logic [N_CH-1:0]   lock_toggled,
  output logic              shift_held,
  output logic              capital
);

  typedef enum logic [1:0] {
    OFF      = 2'b00,
    ON_HELD  = 2'b01,
    ON       = 2'b10,
    OFF_HELD = 2'b11
  } ch_state_e;

  ch_state_e         state_q [N_CH];
  ch_state_e         state_d [N_CH];
  logic [N_CH-1:0]   lock_q, lock_d;
  logic [N_CH-1:0]   toggled_q, toggled_d;
  logic              shift_q, shift_d;
  logic              capital_q, capital_d;

  always_comb begin
    logic [8:0] code;
    logic       held;
    logic       press;
    for (int i = 0; i < N_CH; i++) begin
      code       = KEY_CODES[9*i +: 9];
      held       = key_down[code];
      press      = key_valid && (last_change == code) && held;
      state_d[i] = state_q[i];
      lock_d[i]  = 1'b0;
      if (MOMENTARY_MASK[i]) begin
        state_d[i] = OFF;
        lock_d[i]  = held;
      end else begin
        if (clear_all) begin
          state_d[i] = OFF;
        end else begin
          case (state_q[i])
            OFF:      if (press) state_d[i] = ON_HELD;
            ON_HELD:  if (!held) state_d[i] = ON;
            ON:       if (press) state_d[i] = OFF_HELD;
            OFF_HELD: if (!held) state_d[i] = OFF;
            default:             state_d[i] = OFF;
          endcase
        end
        // Lock is on exactly in ON_HELD and ON, i.e. when the two state bits differ.
        lock_d[i] = state_d[i][0] ^ state_d[i][1];
      end
    end
    toggled_d = lock_d ^ lock_q;
    shift_d   = key_down[LSHIFT_CODE] | key_down[RSHIFT_CODE];
    capital_d = lock_d[CAPS_IDX] ^ shift_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) state_q[i] <= OFF;
      lock_q    <= '0;
      toggled_q <= '0;
      shift_q   <= 1'b0;
      capital_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) state_q[i] <= state_d[i];
      lock_q    <= lock_d;
      toggled_q <= toggled_d;
      shift_q   <= shift_d;
      capital_q <= capital_d;
    end
  end

  assign lock_state   = lock_q;
  assign lock_toggled = toggled_q;
  assign shift_held   = shift_q;
  assign capital      = capital_q;

endmodule
